// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves data load/store requests and instruction
// fetches over an 8-bit synchronous RAM port, data requests taking priority.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_data,
  input  logic [3:0]  mem_req_type,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);
  localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5,
                         SB = 4'd6, SH = 4'd7, SW = 4'd8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, addr_nx, data_q, data_nx, word_q, word_nx;
  logic [3:0]  type_q, type_nx;
  logic        fetch_q, fetch_nx;
  logic [2:0]  n_q, n_nx, cnt, cnt_nx;
  logic [1:0]  bi;
  logic        mem_done_nx, if_done_nx, ram_wr_nx;
  logic [31:0] mem_rdata_nx, if_inst_nx, ram_a_nx;
  logic [7:0]  ram_dout_nx;

  function automatic logic [2:0] width_of(input logic [3:0] t);
    case (t)
      LB, LBU, SB: width_of = 3'd1;
      LH, LHU, SH: width_of = 3'd2;
      default:     width_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [3:0] t, input logic [31:0] w);
    case (t)
      LB:      extend = {{24{w[7]}}, w[7:0]};
      LH:      extend = {{16{w[15]}}, w[15:0]};
      LBU:     extend = {24'd0, w[7:0]};
      LHU:     extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // READ runs one cycle past the last address: cnt is the number of addresses
  // already presented, and ram_din carries byte cnt-1 in the current cycle.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    data_nx      = data_q;
    type_nx      = type_q;
    fetch_nx     = fetch_q;
    n_nx         = n_q;
    cnt_nx       = cnt;
    word_nx      = word_q;
    mem_done_nx  = 1'b0;
    if_done_nx   = 1'b0;
    mem_rdata_nx = mem_rdata;
    if_inst_nx   = if_inst;
    ram_a_nx     = '0;
    ram_dout_nx  = '0;
    ram_wr_nx    = 1'b0;
    bi           = 2'd0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          addr_nx  = mem_req_addr;
          data_nx  = mem_req_data;
          type_nx  = mem_req_type;
          fetch_nx = 1'b0;
          n_nx     = width_of(mem_req_type);
          cnt_nx   = '0;
          word_nx  = '0;
          if (mem_req_type >= LB && mem_req_type <= LHU) begin
            state_nx = READ;
            ram_a_nx = mem_req_addr;
          end else if (mem_req_type >= SB && mem_req_type <= SW) begin
            state_nx    = WRITE;
            ram_a_nx    = mem_req_addr;
            ram_dout_nx = mem_req_data[7:0];
            ram_wr_nx   = 1'b1;
          end else begin
            state_nx     = DONE;
            mem_done_nx  = 1'b1;
            mem_rdata_nx = '0;
          end
        end else if (if_req) begin
          addr_nx  = if_addr;
          type_nx  = LW;
          fetch_nx = 1'b1;
          n_nx     = 3'd4;
          cnt_nx   = '0;
          word_nx  = '0;
          state_nx = READ;
          ram_a_nx = if_addr;
        end
      end
      READ: begin
        if (cnt != 3'd0) begin
          bi = cnt[1:0] - 2'd1;
          word_nx[{bi, 3'b000} +: 8] = ram_din;
        end
        if (cnt == n_q) begin
          state_nx = DONE;
          if (fetch_q) begin
            if_done_nx = 1'b1;
            if_inst_nx = word_nx;
          end else begin
            mem_done_nx  = 1'b1;
            mem_rdata_nx = extend(type_q, word_nx);
          end
        end else begin
          cnt_nx = cnt + 3'd1;
          if (cnt + 3'd1 < n_q) ram_a_nx = addr_q + 32'(cnt + 3'd1);
        end
      end
      WRITE: begin
        if (cnt == n_q - 3'd1) begin
          state_nx    = DONE;
          mem_done_nx = 1'b1;
        end else begin
          cnt_nx      = cnt + 3'd1;
          bi          = cnt[1:0] + 2'd1;
          ram_a_nx    = addr_q + 32'(cnt + 3'd1);
          ram_dout_nx = data_q[{bi, 3'b000} +: 8];
          ram_wr_nx   = 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      type_q    <= '0;
      fetch_q   <= 1'b0;
      n_q       <= '0;
      cnt       <= '0;
      word_q    <= '0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      data_q    <= data_nx;
      type_q    <= type_nx;
      fetch_q   <= fetch_nx;
      n_q       <= n_nx;
      cnt       <= cnt_nx;
      word_q    <= word_nx;
      mem_busy  <= (state_nx != IDLE);
      mem_done  <= mem_done_nx;
      mem_rdata <= mem_rdata_nx;
      if_done   <= if_done_nx;
      if_inst   <= if_inst_nx;
      ram_a     <= ram_a_nx;
      ram_dout  <= ram_dout_nx;
      ram_wr    <= ram_wr_nx;
    end
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller at the RAM end of the data-request interface driven by the MEM stage, also serving instruction fetch. Accepts one word, halfword or byte load/store request at a time, runs it as a byte-serial little-endian sequence on the 8-bit synchronous RAM port, and returns a one-cycle done pulse with sign- or zero-extended load data. Data requests take priority over instruction fetches.

## Interface
- No parameters. Request-type encoding, fixed:
  - mem_LB=1, mem_LH=2, mem_LW=3, mem_LBU=4, mem_LHU=5
  - mem_SB=6, mem_SH=7, mem_SW=8
  - all other values are invalid.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- mem_req  in  1  data request valid; held with its fields stable until mem_done
- mem_req_addr  in  32  byte address
- mem_req_data  in  32  store data; low bytes used for SB/SH
- mem_req_type  in  4  encoding above
- mem_busy  out  1  high whenever state ≠ IDLE; a requester launches only when low
- mem_done  out  1  one-cycle completion pulse for a data request
- mem_rdata  out  32  extended load result; valid while mem_done=1
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_inst  out  32  fetched word; valid while if_done=1
- ram_din  in  8  RAM read data; returns the byte addressed in the previous cycle
- ram_dout  out  8  RAM write data
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout to ram_a at the next edge

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, at each edge:
  - mem_req=1 → accept the data request; it wins over if_req.
  - else if_req=1 → accept the fetch as a 4-byte read.
  - else stay in IDLE.
- Accept latches address, type, store data, source (data/fetch) and byte count N, and clears byte counter i:
  - N=1 for B/BU, 2 for H/HU, 4 for W and fetch.
- READ:
  - Present ram_a = addr+i for i = 0..N-1, one byte per cycle, ram_wr=0.
  - Capture byte j from ram_din one cycle after addr+j was presented, into bits [8j+7:8j].
  - After byte N-1 is captured → DONE.
- WRITE:
  - Present ram_a = addr+i, ram_dout = data[8i+7:8i], ram_wr=1 for i = 0..N-1.
  - After byte N-1 → DONE.
- DONE, one cycle:
  - Pulse mem_done or if_done according to source.
  - ram_wr=0; no request is accepted.
  - Return to IDLE.
  - The requester must drop its request, or present a new one, before the following edge.
- Result extension:
  - LB, LH: sign-extend from bit 7 or bit 15.
  - LBU, LHU: zero-extend.
  - LW and fetch: raw word.
- Invalid type: accepted, no RAM access, DONE the next cycle with mem_rdata=0.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check is made; misaligned accesses proceed byte-wise.
- Outside READ/WRITE: ram_a=0, ram_dout=0, ram_wr=0.

## Timing
- All outputs are registered.
- Reset values: mem_busy=0, mem_done=0, mem_rdata=0, if_done=0, if_inst=0, ram_a=0, ram_dout=0, ram_wr=0; state IDLE.
- Accept at edge E0:
  - Byte i address is on ram_a in cycle i+1 after E0.
  - Loads: done high in cycle N+2 after E0 (LW/fetch: 6; LB: 3).
  - Stores: done high in cycle N+1 after E0 (SW: 5; SB: 2).
- mem_busy rises in the cycle after E0 and stays high through the DONE cycle.
- Back-to-back requests: the earliest next accept is the edge ending the IDLE cycle that follows DONE.
- mem_req and if_req asserted at the same IDLE edge: the data request is served. The fetch remains pending and is accepted at the next IDLE edge unless a new mem_req arrives.
- rst mid-operation: the state returns to IDLE at that edge and all outputs take their reset values. ram_wr is therefore low from the cycle after the reset edge; no further bytes are written and no done pulse is issued for the aborted request.

## Test plan
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 → ram_a runs 0x100..0x103 in cycles 1–4; mem_done in cycle 6 with mem_rdata=0x44332211; mem_busy high cycles 1–6.
- LB and LBU at an address holding 0x80 → mem_rdata=0xFFFFFF80 and 0x00000080 respectively. LH/LHU on 0x8001 → 0xFFFF8001 and 0x00008001.
- SH at 0x200, data 0xDEADBEEF → writes 0xEF@0x200 then 0xBE@0x201, ram_wr high 2 cycles; mem_done in cycle 3; 0x202 untouched.
- mem_req (SB) and if_req asserted at the same edge → SB completes first. The fetch is accepted at the next IDLE edge and if_done follows 6 cycles later with the correct word.
- rst pulsed during the 2nd byte of SW → ram_wr=0 from the next cycle; only byte 0 (and byte 1 if its write edge coincides with reset) is written; no mem_done; all outputs at reset values.
- LW at 0xFFFFFFFE → addresses wrap to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Invalid type 0xF → mem_done in the next cycle with 0, ram_wr never high.
